// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port (MSB first), length (MSB first),
// data (LSB first), then one high GAP tick. Advances only on clkEn ticks.
module serial_frame_tx #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int PORT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [PORT_W-1:0] port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              SerOut,
  output logic              busy,
  output logic              Done
);

  localparam int CW_D  = $clog2(DATA_W);
  localparam int CW_L  = $clog2(LEN_W);
  localparam int CW_P  = $clog2(PORT_W);
  localparam int CW_DL = (CW_D > CW_L) ? CW_D : CW_L;
  localparam int CNT_W = ((CW_DL > CW_P) ? CW_DL : CW_P) + 1;

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA, GAP} state_e;

  state_e              state_q, state_d;
  logic                ser_q, ser_d;
  logic                done_q, done_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    len_sh_q, len_sh_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_clamp;

  assign len_clamp = (32'(len) > DATA_W) ? LEN_W'(DATA_W) : len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ser_q    <= 1'b1;
      done_q   <= 1'b0;
      port_q   <= '0;
      len_q    <= '0;
      len_sh_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ser_q    <= ser_d;
      done_q   <= done_d;
      port_q   <= port_d;
      len_q    <= len_d;
      len_sh_q <= len_sh_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  // Port and length are shifted out of copies so the MSB is always the next bit;
  // len_q keeps the untouched value for the zero check and data count.
  always_comb begin
    state_d  = state_q;
    ser_d    = ser_q;
    done_d   = 1'b0;
    port_d   = port_q;
    len_d    = len_q;
    len_sh_d = len_sh_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    if (clkEn) begin
      case (state_q)
        IDLE: begin
          ser_d = 1'b1;
          if (start) begin
            state_d  = START;
            ser_d    = 1'b0;
            port_d   = port;
            len_d    = len_clamp;
            len_sh_d = len_clamp;
            data_d   = data;
          end
        end
        START: begin
          state_d = PORT;
          ser_d   = port_q[PORT_W-1];
          port_d  = port_q << 1;
          cnt_d   = CNT_W'(PORT_W - 1);
        end
        PORT: begin
          if (cnt_q == '0) begin
            state_d  = LEN;
            ser_d    = len_sh_q[LEN_W-1];
            len_sh_d = len_sh_q << 1;
            cnt_d    = CNT_W'(LEN_W - 1);
          end else begin
            ser_d  = port_q[PORT_W-1];
            port_d = port_q << 1;
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
        LEN: begin
          if (cnt_q == '0) begin
            if (len_q == '0) begin
              state_d = GAP;
              ser_d   = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = DATA;
              ser_d   = data_q[0];
              data_d  = data_q >> 1;
              cnt_d   = CNT_W'(len_q) - CNT_W'(1);
            end
          end else begin
            ser_d    = len_sh_q[LEN_W-1];
            len_sh_d = len_sh_q << 1;
            cnt_d    = cnt_q - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            state_d = GAP;
            ser_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            ser_d  = data_q[0];
            data_d = data_q >> 1;
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          state_d = IDLE;
          ser_d   = 1'b1;
        end
        default: begin
          state_d = IDLE;
          ser_d   = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != IDLE);
    SerOut = ser_q;
    Done   = done_q;
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: stimulus queues hand-computed bit
// streams, a monitor pops one entry per busy tick and compares SerOut/Done.
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn;
  logic        start;
  logic [1:0]  port;
  logic [3:0]  len;
  logic [15:0] data;
  logic        SerOut;
  logic        busy;
  logic        Done;

  serial_frame_tx #(.DATA_W(16), .LEN_W(4), .PORT_W(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .clkEn  (clkEn),
    .start  (start),
    .port   (port),
    .len    (len),
    .data   (data),
    .SerOut (SerOut),
    .busy   (busy),
    .Done   (Done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ser;
    logic done;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          sparse = 1'b0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned busy_ticks = 0;
  int unsigned idle_run = 0;
  int unsigned last_gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Clock enable: every cycle, or every 4th cycle in sparse mode.
  initial begin
    clkEn = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      clkEn = sparse ? (cyc % 4 == 0) : 1'b1;
    end
  end

  // Monitor: one expected entry per tick while busy; holds checked between ticks.
  initial begin
    logic en;
    logic prev_busy;
    logic last_ser;
    exp_t e;
    prev_busy = 1'b0;
    last_ser  = 1'b1;
    forever begin
      @(posedge clk);
      en = clkEn;
      #1;
      if (!rst) begin
        if (en) begin
          if (busy) begin
            busy_ticks++;
            if (!prev_busy) begin
              last_gap = idle_run;
              idle_run = 0;
            end
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_bit: DUT busy with SerOut=%b, no bit expected (t=%0t)",
                       SerOut, $time);
            end else begin
              e = exp_q.pop_front();
              check("ser", {31'd0, SerOut}, {31'd0, e.ser});
              check("done", {31'd0, Done}, {31'd0, e.done});
            end
          end else begin
            idle_run++;
            check("idle_line", {31'd0, SerOut}, 32'd1);
          end
          if (Done) done_cnt++;
        end else begin
          check("hold", {30'd0, SerOut, Done}, {30'd0, last_ser, 1'b0});
        end
        prev_busy = busy;
        last_ser  = SerOut;
      end else begin
        prev_busy = 1'b0;
        last_ser  = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pushes n bits, first-sent bit at position n-1; the last is the GAP bit.
  task automatic push_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back('{ser: bits[i], done: (i == 0)});
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int k;
    k = 0;
    while (busy !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic send(input logic [1:0] p, input logic [3:0] l, input logic [15:0] d,
                      input int budget);
    @(negedge clk);
    port  = p;
    len   = l;
    data  = d;
    start = 1'b1;
    wait_busy(1'b1, budget, "busy_rise");
    start = 1'b0;
    wait_busy(1'b0, budget, "busy_fall");
    @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned base;
    int k;
    rst   = 1'b1;
    start = 1'b0;
    port  = '0;
    len   = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ser", {31'd0, SerOut}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame
    push_bits(64'b01000111011, 11);
    busy_ticks = 0;
    send(2'b10, 4'd3, 16'h0005, 100);
    check("basic_busy_ticks", busy_ticks, 32'd11);
    check("basic_done_cnt", done_cnt, 32'd1);

    // Zero length
    push_bits(64'b00100001, 8);
    busy_ticks = 0;
    send(2'b01, 4'd0, 16'hFFFF, 100);
    check("zero_busy_ticks", busy_ticks, 32'd8);
    check("zero_done_cnt", done_cnt, 32'd2);

    // Max length, clkEn every 4th cycle
    sparse = 1'b1;
    push_bits(64'b01111111100001110100101, 23);
    busy_ticks = 0;
    send(2'b11, 4'd15, 16'hA5C3, 400);
    check("max_busy_ticks", busy_ticks, 32'd23);
    check("max_done_cnt", done_cnt, 32'd3);
    sparse = 1'b0;
    repeat (8) @(negedge clk);

    // Busy protection: start and input changes during DATA are ignored
    push_bits(64'b0010010011, 10);
    @(negedge clk);
    port  = 2'b01;
    len   = 4'd2;
    data  = 16'h0002;
    start = 1'b1;
    wait_busy(1'b1, 50, "prot_busy_rise");
    start = 1'b0;
    repeat (7) @(negedge clk);
    port  = 2'b00;
    len   = 4'd4;
    data  = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_busy(1'b0, 50, "prot_busy_fall");
    repeat (6) @(negedge clk);
    check("prot_no_restart", {31'd0, busy}, 32'd0);
    check("prot_drain", exp_q.size(), 32'd0);
    check("prot_done_cnt", done_cnt, 32'd4);

    // Reset during LEN
    push_bits(64'b01000111011, 11);
    @(negedge clk);
    port  = 2'b10;
    len   = 4'd3;
    data  = 16'h0005;
    start = 1'b1;
    wait_busy(1'b1, 50, "rstm_busy_rise");
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rstm_pre_ser", {31'd0, SerOut}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rstm_ser", {31'd0, SerOut}, 32'd1);
    check("rstm_busy", {31'd0, busy}, 32'd0);
    check("rstm_done", {31'd0, Done}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_bits(64'b000000111, 9);
    send(2'b00, 4'd1, 16'h0001, 100);
    check("rstm_done_cnt", done_cnt, 32'd5);

    // Back-to-back with start held high
    push_bits(64'b010000101, 9);
    push_bits(64'b010000101, 9);
    base = done_cnt;
    @(negedge clk);
    port  = 2'b10;
    len   = 4'd1;
    data  = 16'h0000;
    start = 1'b1;
    k = 0;
    while (done_cnt < base + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("b2b_done_pulses", done_cnt - base, 32'd2);
    wait_busy(1'b0, 50, "b2b_busy_fall");
    @(negedge clk);
    check("b2b_drain", exp_q.size(), 32'd0);
    check("b2b_idle_ticks_between", last_gap, 32'd1);
    repeat (4) @(negedge clk);
    check("b2b_stopped", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Upstream stage of the serial port-demux receiver; generates the SerIn bit stream that the receiver controller consumes.
- Latches a port number, a data length and a data word on a start request, then shifts out a framed serial stream: start bit, port, length, data.
- Line idles high.
- Advances only on clkEn ticks, matching the receiver's timing.

Parameters:
- DATA_W, 16, width of the data word; maximum data bits per frame.
- LEN_W, 4, width of the length field; must satisfy 2**LEN_W >= DATA_W.
- PORT_W, 2, width of the port-number field.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clkEn  input  1  bit-tick enable; all state and SerOut updates occur only on clk edges with clkEn=1.
- start  input  1  frame request; sampled only in IDLE on a clkEn tick.
- port  input  PORT_W  destination port number; latched at start.
- len  input  LEN_W  number of data bits (0..DATA_W); latched at start.
- data  input  DATA_W  payload; latched at start.
- SerOut  output  1  serial line to the receiver's SerIn; registered.
- busy  output  1  high whenever state != IDLE.
- Done  output  1  one-clk-cycle pulse at frame completion.

Behaviour:
- Reset (async, rst=1): state=IDLE, SerOut=1, busy=0, Done=0, all internal registers cleared; takes effect immediately, including mid-frame.
- States: IDLE, START, PORT, LEN, DATA, GAP. Every transition requires a clkEn tick; with clkEn=0 all registers hold.
- IDLE:
  - SerOut=1.
  - On a tick with start=1: latch port, len and data (len values > DATA_W are clamped to DATA_W); go to START; SerOut<=0.
  - start=1 on a non-tick clk edge is ignored; start is not edge-detected.
- START: one tick of SerOut=0. Next tick: go to PORT; SerOut<=port[PORT_W-1].
- PORT: PORT_W ticks, port bits MSB first. Last port bit is followed by LEN; SerOut<=len[LEN_W-1].
- LEN: LEN_W ticks, len bits MSB first. After the last len bit:
  - latched len=0 -> GAP;
  - otherwise -> DATA with SerOut<=data[0].
- DATA: exactly len ticks, data LSB first (data[0] .. data[len-1]). After the last data bit -> GAP.
- GAP:
  - On entry, SerOut<=1 and Done=1 for exactly one clk cycle, on the tick edge of entry.
  - Next tick -> IDLE.
  - This guarantees at least 2 high ticks between frames (GAP plus one IDLE tick before the next start bit).
- Frame length: 1 + PORT_W + LEN_W + len bit-ticks (7 + len at defaults), then the GAP tick.
- Counters:
  - One bit counter of width max(clog2(DATA_W), clog2(LEN_W), clog2(PORT_W))+1 is reloaded at each field entry.
  - No wrap occurs; the counter terminates on the field's last bit.
- start while busy: ignored, no queuing.
- port, len and data changes while busy: no effect.
- start held high continuously: a new frame begins at the first IDLE tick after GAP.
- busy is combinational from the state register; Done is registered.

Test Plan:
- Basic frame: clkEn=1, port=2'b10, len=3, data=16'h0005, pulse start.
  - SerOut over successive ticks: 0,1,0,0,0,1,1,1,0,1, then 1.
  - Done pulses once on the GAP entry; busy high for 11 ticks.
- Zero length: port=2'b01, len=0, start.
  - SerOut: 0,0,1,0,0,0,0, then GAP 1.
  - Done fires 7 ticks after START entry; no data bits sent.
- Max length with sparse clkEn: clkEn high every 4th cycle, port=2'b11, len=15, data=16'hA5C3.
  - 22 bit-ticks emitted, each SerOut value held 4 clk cycles.
  - Data bits are data[0..14] LSB first.
  - Done is exactly 1 clk cycle wide.
- Busy protection: start frame A (len=2); during DATA, pulse start with port=0, len=4 and change the data input.
  - Frame A completes unchanged.
  - No second frame starts until start is reasserted in IDLE.
- Reset mid-frame: assert rst during LEN.
  - SerOut=1, busy=0, Done=0 asynchronously.
  - After release, a new start produces a clean frame from the start bit.
- Back-to-back: start held high, two frames (len=1 each).
  - Exactly 2 high ticks (GAP plus IDLE) separate the frames.
  - Done pulses twice.
